// File: rtl/fp16_multiply.sv
// rtl/fp16_multiply.sv - three-cycle binary16 multiplier with RNE rounding and flush-to-zero
module fp16_multiply (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in_A,
  input  logic [15:0] in_B,
  input  logic        in_En,
  output logic [15:0] out_Out,
  output logic        out_Ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    NORM = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   load_ops;

  // Latched operands
  logic [15:0] a_q;
  logic [15:0] b_q;

  // MULT-stage results
  logic               sign_q;
  logic signed [7:0]  exp_q;
  logic [21:0]        prod_q;
  logic               nan_q;
  logic               inf_q;
  logic               zero_q;

  // Operand decode from the latched operands
  logic [4:0]  exp_a;
  logic [4:0]  exp_b;
  logic [9:0]  frac_a;
  logic [9:0]  frac_b;
  logic        is_nan_a;
  logic        is_nan_b;
  logic        is_inf_a;
  logic        is_inf_b;
  logic        is_zero_a;
  logic        is_zero_b;
  logic [21:0] prod_c;
  logic signed [7:0] exp_sum_c;

  // NORM-stage combinational result
  logic [9:0]        frac_n;
  logic              guard;
  logic              sticky;
  logic              round_up;
  logic [10:0]       frac_rnd;
  logic signed [7:0] exp_n;
  logic signed [7:0] exp_r;
  logic [15:0]       result;

  // Next-state and operand-load decode
  always_comb begin
    state_d  = state_q;
    load_ops = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_En) begin
          load_ops = 1'b1;
          state_d  = MULT;
        end
      end
      MULT:    state_d = NORM;
      NORM:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Unpack operands; subnormals are classified as zero so they flush
  always_comb begin
    exp_a     = a_q[14:10];
    exp_b     = b_q[14:10];
    frac_a    = a_q[9:0];
    frac_b    = b_q[9:0];
    is_nan_a  = (exp_a == 5'h1F) && (frac_a != 10'd0);
    is_nan_b  = (exp_b == 5'h1F) && (frac_b != 10'd0);
    is_inf_a  = (exp_a == 5'h1F) && (frac_a == 10'd0);
    is_inf_b  = (exp_b == 5'h1F) && (frac_b == 10'd0);
    is_zero_a = (exp_a == 5'h00);
    is_zero_b = (exp_b == 5'h00);
    prod_c    = {11'd0, 1'b1, frac_a} * {11'd0, 1'b1, frac_b};
    exp_sum_c = $signed({3'b000, exp_a}) + $signed({3'b000, exp_b}) - 8'sd15;
  end

  // Operand latch and MULT-stage registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= 16'h0000;
      b_q    <= 16'h0000;
      sign_q <= 1'b0;
      exp_q  <= 8'sd0;
      prod_q <= 22'd0;
      nan_q  <= 1'b0;
      inf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      if (load_ops) begin
        a_q <= in_A;
        b_q <= in_B;
      end
      if (state_q == MULT) begin
        sign_q <= a_q[15] ^ b_q[15];
        exp_q  <= exp_sum_c;
        prod_q <= prod_c;
        nan_q  <= is_nan_a || is_nan_b || (is_inf_a && is_zero_b) || (is_inf_b && is_zero_a);
        inf_q  <= is_inf_a || is_inf_b;
        zero_q <= is_zero_a || is_zero_b;
      end
    end
  end

  // Normalise, round to nearest even, then apply range and special-case overrides
  always_comb begin
    if (prod_q[21]) begin
      frac_n = prod_q[20:11];
      guard  = prod_q[10];
      sticky = |prod_q[9:0];
      exp_n  = exp_q + 8'sd1;
    end else begin
      frac_n = prod_q[19:10];
      guard  = prod_q[9];
      sticky = |prod_q[8:0];
      exp_n  = exp_q;
    end
    round_up = guard && (sticky || frac_n[0]);
    // A carry out means the significand became 10.0, so fraction wraps to zero
    frac_rnd = {1'b0, frac_n} + {10'd0, round_up};
    exp_r    = frac_rnd[10] ? (exp_n + 8'sd1) : exp_n;

    if (nan_q) begin
      result = 16'h7E00;
    end else if (inf_q) begin
      result = {sign_q, 5'h1F, 10'd0};
    end else if (zero_q) begin
      result = {sign_q, 15'd0};
    end else if (exp_r >= 8'sd31) begin
      result = {sign_q, 5'h1F, 10'd0};
    end else if (exp_r <= 8'sd0) begin
      result = {sign_q, 15'd0};
    end else begin
      result = {sign_q, exp_r[4:0], frac_rnd[9:0]};
    end
  end

  // Output register: updated only on the NORM edge, Ready pulses for that one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      out_Out   <= 16'h0000;
      out_Ready <= 1'b0;
    end else begin
      out_Ready <= (state_q == NORM);
      if (state_q == NORM) begin
        out_Out <= result;
      end
    end
  end

endmodule

// File: tb/tb_fp16_multiply.sv
// tb/tb_fp16_multiply.sv - directed-vector self-checking bench for fp16_multiply
module tb_fp16_multiply;

  logic        clk;
  logic        rst;
  logic [15:0] in_A;
  logic [15:0] in_B;
  logic        in_En;
  logic [15:0] out_Out;
  logic        out_Ready;

  int n_checks;
  int n_fail;

  fp16_multiply dut (
    .clk       (clk),
    .rst       (rst),
    .in_A      (in_A),
    .in_B      (in_B),
    .in_En     (in_En),
    .out_Out   (out_Out),
    .out_Ready (out_Ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated operation: strobe at edge N, expect Ready right after edge N+2, gone after N+3
  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] expected);
    int lat;
    in_A  = a;
    in_B  = b;
    in_En = 1'b1;
    tick();
    in_En = 1'b0;
    in_A  = 16'hDEAD;
    in_B  = 16'hBEEF;
    lat   = 0;
    while (!out_Ready && lat < 8) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, 2);
    check({tag, "_result"}, out_Out, expected);
    tick();
    check({tag, "_ready_fall"}, out_Ready, 0);
    check({tag, "_hold"}, out_Out, expected);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst   = 1'b1;
    in_A  = 16'h0000;
    in_B  = 16'h0000;
    in_En = 1'b0;
    tick();
    rst = 1'b0;

    check("reset_out", out_Out, 16'h0000);
    check("reset_ready", out_Ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_ready", out_Ready, 0);
      check("idle_out", out_Out, 16'h0000);
    end

    do_op("rne_123", 16'h57B7, 16'hD7B7, 16'hF371);
    do_op("one_x_two", 16'h3C00, 16'h4000, 16'h4000);
    do_op("sq_1p5", 16'h3E00, 16'h3E00, 16'h4080);
    do_op("rne_down", 16'h3C01, 16'h3C01, 16'h3C02);
    do_op("ovf_pos", 16'h7BFF, 16'h7BFF, 16'h7C00);
    do_op("ovf_neg", 16'hFBFF, 16'h7BFF, 16'hFC00);
    do_op("unf", 16'h0400, 16'h3800, 16'h0000);
    do_op("subn_ftz", 16'h0001, 16'h3C00, 16'h0000);
    do_op("inf_x_zero", 16'h7C00, 16'h0000, 16'h7E00);
    do_op("nan_in", 16'h7E00, 16'h3C00, 16'h7E00);
    do_op("neg_inf", 16'hFC00, 16'h4000, 16'hFC00);
    do_op("neg_zero", 16'h8000, 16'h3C00, 16'h8000);

    // in_En held for four edges: only edge N and edge N+3 operands are taken
    in_A = 16'h3C00; in_B = 16'h4000; in_En = 1'b1;
    tick();
    in_A = 16'h7BFF; in_B = 16'h7BFF;
    tick();
    check("held_n1_ready", out_Ready, 0);
    in_A = 16'h7E00; in_B = 16'h3C00;
    tick();
    check("held_n2_ready", out_Ready, 1);
    check("held_n2_out", out_Out, 16'h4000);
    in_A = 16'h3E00; in_B = 16'h3E00;
    tick();
    check("held_n3_ready", out_Ready, 0);
    in_En = 1'b0;
    in_A  = 16'h7C00; in_B = 16'h0000;
    tick();
    check("held_n4_ready", out_Ready, 0);
    check("held_n4_out", out_Out, 16'h4000);
    tick();
    check("held_n5_ready", out_Ready, 1);
    check("held_n5_out", out_Out, 16'h4080);
    tick();
    check("held_n6_ready", out_Ready, 0);

    // Reset one edge after the strobe aborts the operation
    in_A = 16'h57B7; in_B = 16'hD7B7; in_En = 1'b1;
    tick();
    in_En = 1'b0;
    rst   = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_out", out_Out, 16'h0000);
    check("abort_ready", out_Ready, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("abort_no_ready", out_Ready, 0);
      check("abort_out_hold", out_Out, 16'h0000);
    end

    // Operation after the abort still works
    do_op("post_abort", 16'h57B7, 16'hD7B7, 16'hF371);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
